sram_stream_reader: RTL and testbench

Read-side master for the 1rw1r 8x1024 frame-buffer SRAM. It drives the read-only port 1 (cs1_n/addr1/rdata1) and turns a programmed address window into a valid/ready byte stream for the LED serializer. CPU/Wishbone writes stay on port 0. The block absorbs the SRAM's fixed one-cycle read latency and downstream backpressure through a 2-entry output FIFO.

---
 rtl/sram_stream_reader_pkg.sv | 15 +
 rtl/sram_stream_fifo2.sv | 51 +++++
 rtl/sram_stream_reader.sv | 140 ++++++++++++++
 tb/tb_sram_stream_reader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_stream_reader_pkg.sv
// rtl/sram_stream_reader_pkg.sv - shared SRAM geometry and reader state encoding
package sram_stream_reader_pkg;

    localparam int SRAM_ADDR_W = 10;
    localparam int SRAM_DATA_W = 8;
    localparam int SRAM_DEPTH  = 1 << SRAM_ADDR_W;
    localparam int SRAM_LEN_W  = SRAM_ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/sram_stream_fifo2.sv
// rtl/sram_stream_fifo2.sv - 2-entry first-word-fall-through FIFO with flush
module sram_stream_fifo2
    import sram_stream_reader_pkg::*;
#(
    parameter int DATA_W = SRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A push into a full FIFO is only accepted when the head leaves the same cycle.
    assign do_pop   = pop && (count != 2'd0);
    assign do_push  = push && ((count != 2'd2) || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/sram_stream_reader.sv
// rtl/sram_stream_reader.sv - SRAM read-port window to byte stream; SRAM_STREAM_READER_LOOP_EN adds loop input
module sram_stream_reader
    import sram_stream_reader_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W,
    parameter int LEN_W  = SRAM_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
`ifdef SRAM_STREAM_READER_LOOP_EN
    input  logic              loop,
`endif
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              sram_cs_n,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  len_q;
    logic              inflight;
    logic              done_q;
    logic              busy_q;
    logic [1:0]        fifo_count;
    logic              pop;
    logic              issue;
    logic              last_pop;
    logic              restart;

`ifdef SRAM_STREAM_READER_LOOP_EN
    assign restart = loop;
`else
    assign restart = 1'b0;
`endif

    assign pop     = m_valid & m_ready;
    assign m_valid = (fifo_count != 2'd0);

    // Buffered plus in-flight bytes, after this cycle's pop, must leave room for one more.
    assign issue = (state == ST_READ) && (remaining != '0) &&
                   (({1'b0, fifo_count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

    assign sram_cs_n = ~issue;
    assign sram_addr = ptr;
    assign busy      = busy_q;
    assign done      = done_q;

    // The final byte leaves the FIFO with nothing left in flight behind it.
    assign last_pop = (state == ST_DRAIN) && !inflight && (fifo_count == 2'd1) && pop;

    sram_stream_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .push      (inflight),
        .push_data (sram_rdata),
        .pop       (pop),
        .pop_data  (m_data),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            base_q    <= '0;
            remaining <= '0;
            len_q     <= '0;
            inflight  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            inflight <= issue;
            if (issue) begin
                ptr       <= ptr + ADDR_W'(1);
                remaining <= remaining - LEN_W'(1);
            end
            if (abort) begin
                state    <= ST_IDLE;
                busy_q   <= 1'b0;
                inflight <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (length != '0) begin
                                base_q    <= base_addr;
                                len_q     <= length;
                                ptr       <= base_addr;
                                remaining <= length;
                                state     <= ST_READ;
                                busy_q    <= 1'b1;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                    ST_READ: begin
                        if (issue && (remaining == LEN_W'(1))) begin
                            state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (last_pop) begin
                            done_q <= 1'b1;
                            if (restart) begin
                                ptr       <= base_q;
                                remaining <= len_q;
                                state     <= ST_READ;
                            end else begin
                                state  <= ST_IDLE;
                                busy_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sram_stream_reader.sv
// tb/tb_sram_stream_reader.sv - randomized stream check against a memory-window reference model
module tb_sram_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
`ifdef SRAM_STREAM_READER_LOOP_EN
    logic        loop;
`endif
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic        busy;
    logic        done;
    logic        sram_cs_n;
    logic [9:0]  sram_addr;
    logic [7:0]  sram_rdata;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;

    logic [7:0]  mem [1024];

    int checks = 0;
    int failures = 0;

    sram_stream_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
`ifdef SRAM_STREAM_READER_LOOP_EN
        .loop       (loop),
`endif
        .base_addr  (base_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .sram_cs_n  (sram_cs_n),
        .sram_addr  (sram_addr),
        .sram_rdata (sram_rdata),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_cs_n) sram_rdata <= mem[sram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observation log, filled at the falling edge.
    int         ncyc = 0;
    logic [7:0] data_log[$];
    logic [9:0] addr_log[$];
    int         done_cnt, done_cyc, first_hs_cyc, last_hs_cyc, first_valid_cyc;
    bit         busy_seen;
    int         out_cnt = 0;
    bit         prev_issue = 0, prev_pop = 0, prev_stall = 0, prev_abort = 0;
    logic [7:0] prev_data = '0;

    always @(negedge clk) begin
        ncyc++;
        if (rst_n) begin
            if (prev_abort) out_cnt = 0;
            else out_cnt = out_cnt + int'(prev_issue) - int'(prev_pop);
            if (busy || m_valid) check("outstanding_le2", 32'(out_cnt <= 2), 1);
            if (prev_stall && !prev_abort) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, prev_data);
            end
            if (!sram_cs_n) addr_log.push_back(sram_addr);
            if (m_valid && m_ready) begin
                data_log.push_back(m_data);
                if (first_hs_cyc == 0) first_hs_cyc = ncyc;
                last_hs_cyc = ncyc;
            end
            if (m_valid && first_valid_cyc == 0) first_valid_cyc = ncyc;
            if (done) begin
                done_cnt++;
                done_cyc = ncyc;
            end
            if (busy) busy_seen = 1;
            prev_issue = !sram_cs_n;
            prev_pop   = m_valid && m_ready;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_abort = abort;
        end else begin
            out_cnt = 0;
            prev_issue = 0;
            prev_pop = 0;
            prev_stall = 0;
            prev_abort = 0;
        end
    end

    int mode = 0;
    int pat_i = 0;
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int start_cyc;

    task automatic step();
        @(posedge clk);
        #1;
        case (mode)
            0: m_ready = 1'b1;
            1: m_ready = 1'($urandom_range(0, 1));
            default: begin
                m_ready = pat[pat_i % 6];
                pat_i++;
            end
        endcase
    endtask

    task automatic clear_logs();
        data_log.delete();
        addr_log.delete();
        done_cnt = 0;
        done_cyc = 0;
        first_hs_cyc = 0;
        last_hs_cyc = 0;
        first_valid_cyc = 0;
        busy_seen = 0;
    endtask

    task automatic launch(input int b, input int l);
        clear_logs();
        base_addr = 10'(b);
        length = 11'(l);
        start = 1'b1;
        step();
        start = 1'b0;
        start_cyc = ncyc;
    endtask

    task automatic finish_xfer(input string tag, input int b, input int l, input int passes);
        int budget = 0;
        int n = l * passes;
        while ((done_cnt < passes || busy) && budget < 10000) begin
`ifdef SRAM_STREAM_READER_LOOP_EN
            if (done_cnt >= 1) loop = 1'b0;
`endif
            step();
            budget++;
        end
        check({tag, "_timeout"}, 32'(budget < 10000), 1);
        repeat (3) step();
        check({tag, "_done_cnt"}, done_cnt, passes);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_n_bytes"}, data_log.size(), n);
        check({tag, "_n_reads"}, addr_log.size(), n);
        for (int i = 0; i < n && i < data_log.size(); i++)
            check({tag, "_data"}, data_log[i], mem[(b + i % l) % 1024]);
        for (int i = 0; i < n && i < addr_log.size(); i++)
            check({tag, "_addr"}, addr_log[i], (b + i % l) % 1024);
        check({tag, "_done_after_last"}, done_cyc, last_hs_cyc + 1);
        // Start sampled at E0; first m_valid appears after E0+2, three falling edges later.
        check({tag, "_latency"}, first_valid_cyc, start_cyc + 3);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
`ifdef SRAM_STREAM_READER_LOOP_EN
        loop = 1'b0;
`endif
        m_ready = 1'b1;
        base_addr = '0;
        length = '0;
        sram_rdata = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        #2;
        check("rst_cs_n", sram_cs_n, 1);
        check("rst_addr", sram_addr, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Basic in-order read at full rate
        for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
        mode = 0;
        launch(0, 8);
        finish_xfer("basic", 0, 8, 1);
        check("basic_back_to_back", last_hs_cyc - first_hs_cyc, 7);

        // Address wrap 1023 -> 0
        mem[1022] = 8'hA0; mem[1023] = 8'hA1; mem[0] = 8'hA2; mem[1] = 8'hA3;
        launch(1022, 4);
        finish_xfer("wrap", 1022, 4, 1);

        // Fixed backpressure pattern
        mode = 2;
        pat_i = 0;
        launch(5, 6);
        finish_xfer("bp", 5, 6, 1);

        // Zero-length request
        mode = 0;
        launch(0, 0);
        repeat (5) step();
        check("len0_done_cnt", done_cnt, 1);
        check("len0_done_cyc", done_cyc, start_cyc + 1);
        check("len0_reads", addr_log.size(), 0);
        check("len0_valid", first_valid_cyc, 0);
        check("len0_busy", busy_seen, 0);

        // Abort after three bytes, then a clean follow-up transfer
        launch(100, 16);
        budget = 0;
        while (data_log.size() < 3 && budget < 50) begin
            step();
            budget++;
        end
        check("abort_reach3_timeout", 32'(budget < 50), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_valid", m_valid, 0);
        check("abort_cs_n", sram_cs_n, 1);
        check("abort_busy", busy, 0);
        for (int i = 0; i < 3 && i < data_log.size(); i++)
            check("abort_prefix", data_log[i], mem[100 + i]);
        repeat (10) step();
        check("abort_no_done", done_cnt, 0);
        launch(0, 2);
        finish_xfer("post_abort", 0, 2, 1);

        // Start while busy is ignored
        launch(200, 5);
        step();
        base_addr = 10'd300;
        length = 11'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        finish_xfer("busy_start", 200, 5, 1);

        // Full frame with random backpressure
        mode = 1;
        launch(0, 1024);
        finish_xfer("frame", 0, 1024, 1);

`ifdef SRAM_STREAM_READER_LOOP_EN
        loop = 1'b1;
        launch(512, 1024);
        finish_xfer("loop", 512, 1024, 2);
`endif

        // Asynchronous reset in the middle of a transfer
        launch(0, 64);
        repeat (10) step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_cs_n", sram_cs_n, 1);
        check("arst_addr", sram_addr, 0);
        check("arst_valid", m_valid, 0);
        check("arst_data", m_data, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        mode = 1;
        launch(10, 3);
        finish_xfer("post_reset", 10, 3, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
